// File: rtl/alu_issue_stage.sv
// alu_issue_stage: command FIFO feeding an external ALU, with a registered valid/ready result stage
// Ports: clk/reset (sync, active-low); cmd_* producer handshake with {op,a,b};
//   alu_*_o head-of-FIFO operands to the ALU, alu_res_i its combinational result;
//   res_* consumer handshake with captured result and op; fifo_count_o occupancy;
//   issued_cnt_o wrapping count of commands retired into the result register.
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [2:0]                 cmd_op_i,
  input  logic [7:0]                 cmd_a_i,
  input  logic [7:0]                 cmd_b_i,
  output logic [7:0]                 alu_a_o,
  output logic [7:0]                 alu_b_o,
  output logic [2:0]                 alu_op_o,
  input  logic [7:0]                 alu_res_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [7:0]                 res_data_o,
  output logic [2:0]                 res_op_o,
  output logic [$clog2(DEPTH):0]     fifo_count_o,
  output logic [CW-1:0]              issued_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  logic [18:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [NW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [18:0]   w_head;
  assign w_empty      = r_count == '0;
  assign cmd_ready_o  = r_count < NW'(DEPTH);
  assign w_push       = cmd_valid_i & cmd_ready_o;
  assign w_pop        = ~w_empty & (~res_valid_o | res_ready_i);
  assign w_head       = r_mem[r_rd];
  assign {alu_op_o, alu_a_o, alu_b_o} = w_empty ? 19'd0 : w_head;
  assign fifo_count_o = r_count;
  // Storage has no reset: stale entries are never visible because the outputs are gated by w_empty.
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= {cmd_op_i, cmd_a_i, cmd_b_i};
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr         <= '0;
      r_rd         <= '0;
      r_count      <= '0;
      res_valid_o  <= 1'b0;
      res_data_o   <= 8'h00;
      res_op_o     <= 3'b000;
      issued_cnt_o <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) begin
        r_rd         <= r_rd + AW'(1);
        res_data_o   <= alu_res_i;
        res_op_o     <= alu_op_o;
        res_valid_o  <= 1'b1;
        issued_cnt_o <= issued_cnt_o + CW'(1);
      end else if (res_ready_i) begin
        res_valid_o  <= 1'b0;
      end
      r_count <= r_count + NW'(w_push) - NW'(w_pop);
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random checks of alu_issue_stage against a queue-based reference model
module tb_alu_issue_stage;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;
  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [2:0] cmd_op_i;
  logic [7:0] cmd_a_i;
  logic [7:0] cmd_b_i;
  logic [7:0] alu_a_o;
  logic [7:0] alu_b_o;
  logic [2:0] alu_op_o;
  logic [7:0] alu_res_i;
  logic       res_valid_o;
  logic       res_ready_i;
  logic [7:0] res_data_o;
  logic [2:0] res_op_o;
  logic [2:0] fifo_count_o;
  logic [CW-1:0] issued_cnt_o;
  int n_chk  = 0;
  int n_fail = 0;
  cmd_t       q[$];
  bit         mv = 0;
  logic [7:0] md = 8'h00;
  logic [2:0] mo = 3'b000;
  int unsigned mi = 0;
  bit         acc;
  alu_issue_stage #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o), .alu_res_i(alu_res_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_op_o(res_op_o),
    .fifo_count_o(fifo_count_o), .issued_cnt_o(issued_cnt_o)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a << b[2:0];
      3'd3: return a >> b[2:0];
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return {7'd0, a == b};
    endcase
  endfunction
  assign alu_res_i = alu_fn(alu_op_o, alu_a_o, alu_b_o);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit rn, input bit v, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input bit rdy, input bit ck, output bit accepted);
    cmd_t h;
    bit push, pop;
    reset = rn; cmd_valid_i = v; cmd_op_i = op; cmd_a_i = a; cmd_b_i = b; res_ready_i = rdy;
    #4;
    h = q.size() != 0 ? q[0] : '{3'd0, 8'd0, 8'd0};
    if (ck) begin
      chk("cmd_ready", 32'(cmd_ready_o), 32'(q.size() < DEPTH));
      chk("fifo_count", 32'(fifo_count_o), 32'(q.size()));
      chk("alu_op", 32'(alu_op_o), 32'(h.op));
      chk("alu_a", 32'(alu_a_o), 32'(h.a));
      chk("alu_b", 32'(alu_b_o), 32'(h.b));
      chk("res_valid", 32'(res_valid_o), 32'(mv));
      chk("res_data", 32'(res_data_o), 32'(md));
      chk("res_op", 32'(res_op_o), 32'(mo));
      chk("issued_cnt", 32'(issued_cnt_o), mi % (1 << CW));
    end
    push = v && q.size() < DEPTH;
    pop  = q.size() != 0 && (!mv || rdy);
    accepted = rn && push;
    if (!rn) begin
      q.delete(); mv = 0; md = 8'h00; mo = 3'b000; mi = 0;
    end else begin
      if (pop) begin
        md = alu_fn(h.op, h.a, h.b); mo = h.op; mv = 1; mi++;
        void'(q.pop_front());
      end else if (rdy) mv = 0;
      if (push) q.push_back('{op, a, b});
    end
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(1, 0, 3'd0, 8'd0, 8'd0, rdy, 1, acc);
  endtask
  initial begin
    int i;
    step(0, 0, 3'd0, 8'd0, 8'd0, 1, 0, acc);
    chk("rst_count", 32'(fifo_count_o), 0);
    chk("rst_valid", 32'(res_valid_o), 0);
    chk("rst_ready", 32'(cmd_ready_o), 1);
    chk("rst_issued", 32'(issued_cnt_o), 0);
    // single ADD
    step(1, 1, 3'd0, 8'h0F, 8'h01, 1, 1, acc);
    step(1, 0, 3'd0, 8'h00, 8'h00, 1, 1, acc);
    chk("add_valid", 32'(res_valid_o), 1);
    chk("add_data", 32'(res_data_o), 32'h10);
    chk("add_issued", 32'(issued_cnt_o), 1);
    step(1, 0, 3'd0, 8'h00, 8'h00, 1, 1, acc);
    chk("add_one_cycle", 32'(res_valid_o), 0);
    // back-to-back stream
    step(1, 1, 3'd1, 8'h05, 8'h07, 1, 1, acc);
    step(1, 1, 3'd2, 8'h81, 8'h03, 1, 1, acc);
    chk("stream_sub", 32'(res_data_o), 32'hFE);
    step(1, 1, 3'd7, 8'h3C, 8'h3C, 1, 1, acc);
    chk("stream_shl", 32'(res_data_o), 32'h08);
    step(1, 0, 3'd0, 8'h00, 8'h00, 1, 1, acc);
    chk("stream_eq", 32'(res_data_o), 32'h01);
    idle(2, 1);
    // backpressure until full
    i = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, 1, 3'($urandom), 8'($urandom), 8'($urandom), 0, 1, acc);
      if (acc) i++;
    end
    chk("full_accepted", 32'(i), 5);
    chk("full_count", 32'(fifo_count_o), 4);
    chk("full_ready", 32'(cmd_ready_o), 0);
    idle(7, 1);
    // simultaneous push/pop at count 2
    for (int k = 0; k < 3; k++) step(1, 1, 3'd6, 8'(k), 8'h5A, 0, 1, acc);
    chk("pp_start", 32'(fifo_count_o), 2);
    for (int k = 0; k < 20; k++) step(1, 1, 3'd0, 8'(k), 8'(k * 3), 1, 1, acc);
    chk("pp_count", 32'(fifo_count_o), 2);
    idle(4, 1);
    // pointer wrap with random stalls
    i = 0;
    for (int t = 0; t < 300 && i < 10; t++) begin
      step(1, 1, 3'd6, 8'(i), 8'hFF, 1'($urandom), 1, acc);
      if (acc) i++;
    end
    chk("wrap_all_pushed", 32'(i), 10);
    for (int k = 0; k < 20; k++) step(1, 0, 3'd0, 8'd0, 8'd0, 1'($urandom), 1, acc);
    idle(6, 1);
    // reset mid-operation
    for (int k = 0; k < 4; k++) step(1, 1, 3'd4, 8'hF0, 8'(k), 0, 1, acc);
    chk("pre_rst_count", 32'(fifo_count_o), 3);
    chk("pre_rst_valid", 32'(res_valid_o), 1);
    step(0, 0, 3'd0, 8'd0, 8'd0, 0, 1, acc);
    chk("mid_rst_count", 32'(fifo_count_o), 0);
    chk("mid_rst_valid", 32'(res_valid_o), 0);
    chk("mid_rst_issued", 32'(issued_cnt_o), 0);
    chk("mid_rst_ready", 32'(cmd_ready_o), 1);
    step(1, 1, 3'd5, 8'hA0, 8'h05, 1, 1, acc);
    step(1, 0, 3'd0, 8'd0, 8'd0, 1, 1, acc);
    chk("post_rst_data", 32'(res_data_o), 32'hA5);
    chk("post_rst_issued", 32'(issued_cnt_o), 1);
    // random traffic
    for (int k = 0; k < 400; k++)
      step(1, 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), 1, acc);
    idle(8, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
